// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front end: feature width, image geometry,
// feeder FSM states and small elaboration-time helpers.
package cnn_pkg;

  localparam int I_F_BW  = 8;
  localparam int IX      = 28;
  localparam int IY      = 28;
  localparam int IMG_PIX = IX * IY;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_t;

  // Ceiling log2, never less than 1 so derived vectors keep a real width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  // Built-in ROM contents when no init file is given: image*1000 + pixel index.
  function automatic int pattern_word(input int addr, input int img_pix);
    return (addr / img_pix) * 1000 + (addr % img_pix);
  endfunction

endpackage

// File: rtl/cnn_image_rom.sv
// Synchronous single-port image ROM with a registered read port.
// Contents are a generated pattern (image*1000 + index, truncated to DW bits).
module cnn_image_rom
  import cnn_pkg::*;
#(
  parameter int    DW        = 8,
  parameter int    NUM_IMG   = 4,
  parameter int    FRAME_PIX = 784,
  parameter int    AW        = 12,
  parameter string INIT_FILE = "image.mem"
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  localparam int DEPTH = NUM_IMG * FRAME_PIX;

  logic [DW-1:0] mem_r [DEPTH];

  // Fill the ROM array with the generated pattern
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_r[i] = DW'(pattern_word(i, FRAME_PIX));
    end
  end

  // Registered read so the array maps onto block RAM
  always_ff @(posedge clk) begin
    data <= mem_r[addr];
  end

endmodule

// File: rtl/cnn_image_feeder.sv
// Streams one stored grayscale image, pixel by pixel in row-major order,
// into the conv stage. A start pulse picks the image with i_sel; reads are
// prefetched into a two-entry skid so a steady i_ready gives 1 pixel/clk.
module cnn_image_feeder
  import cnn_pkg::*;
#(
  parameter int    I_F_BW    = 8,
  parameter int    IX        = 28,
  parameter int    IY        = 28,
  parameter int    NUM_IMG   = 4,
  parameter int    SEL_BW    = 2,
  parameter string INIT_FILE = "image.mem"
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [SEL_BW-1:0] i_sel,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [I_F_BW-1:0] o_pixel,
  output logic              o_first,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int FRAME_PIX = IX * IY;
  localparam int IDX_BW    = clog2(FRAME_PIX);
  localparam int ADDR_BW   = clog2(NUM_IMG * FRAME_PIX);
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(FRAME_PIX - 1);

  feeder_state_t state_r, state_s;

  logic [ADDR_BW-1:0] base_r, base_s, rom_addr_s;
  logic [IDX_BW-1:0]  rd_addr_r;
  logic               issued_all_r;
  logic               rd_inflight_r, rd_first_r, rd_last_r;
  logic [I_F_BW-1:0]  rom_q_s;

  logic               out_valid_r, out_first_r, out_last_r;
  logic [I_F_BW-1:0]  out_pixel_r;
  logic               spare_valid_r, spare_first_r, spare_last_r;
  logic [I_F_BW-1:0]  spare_pixel_r;

  logic               busy_r, done_r;
  logic               start_acc_s, pop_s, last_hs_s, issue_s;
  logic [1:0]         level_s;

  cnn_image_rom #(
    .DW        (I_F_BW),
    .NUM_IMG   (NUM_IMG),
    .FRAME_PIX (FRAME_PIX),
    .AW        (ADDR_BW),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr_s),
    .data (rom_q_s)
  );

  // Handshake, skid occupancy and read-issue decisions
  always_comb begin
    start_acc_s = (state_r == ST_IDLE) && i_start;
    pop_s       = out_valid_r && i_ready;
    last_hs_s   = pop_s && out_last_r;
    // entries held after this edge: what is stored plus the read landing now
    level_s     = 2'(out_valid_r) + 2'(spare_valid_r) + 2'(rd_inflight_r) - 2'(pop_s);
    issue_s     = (state_r == ST_STREAM) && !issued_all_r && (level_s < 2'd2);
    base_s      = ADDR_BW'((int'(i_sel) % NUM_IMG) * FRAME_PIX);
    rom_addr_s  = base_r + ADDR_BW'(rd_addr_r);
  end

  // Next-state logic: IDLE -> STREAM -> DONE -> IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_s = ST_STREAM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_hs_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, status flags and read-address counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      base_r        <= '0;
      rd_addr_r     <= '0;
      issued_all_r  <= 1'b0;
      rd_inflight_r <= 1'b0;
      rd_first_r    <= 1'b0;
      rd_last_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s == ST_STREAM);
      done_r        <= (state_s == ST_DONE);
      rd_inflight_r <= issue_s;
      rd_first_r    <= issue_s && (rd_addr_r == '0);
      rd_last_r     <= issue_s && (rd_addr_r == LAST_IDX);
      if (start_acc_s) begin
        base_r       <= base_s;
        rd_addr_r    <= '0;
        issued_all_r <= 1'b0;
      end else if (issue_s) begin
        // hold on the last pixel so the address never leaves the image
        if (rd_addr_r == LAST_IDX) begin
          issued_all_r <= 1'b1;
        end else begin
          rd_addr_r <= rd_addr_r + IDX_BW'(1);
        end
      end
    end
  end

  // Two-entry skid: the output register refills from the spare first, then from the ROM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r   <= 1'b0;
      out_pixel_r   <= '0;
      out_first_r   <= 1'b0;
      out_last_r    <= 1'b0;
      spare_valid_r <= 1'b0;
      spare_pixel_r <= '0;
      spare_first_r <= 1'b0;
      spare_last_r  <= 1'b0;
    end else begin
      if (pop_s || !out_valid_r) begin
        if (spare_valid_r) begin
          out_valid_r   <= 1'b1;
          out_pixel_r   <= spare_pixel_r;
          out_first_r   <= spare_first_r;
          out_last_r    <= spare_last_r;
          spare_valid_r <= rd_inflight_r;
          spare_pixel_r <= rd_inflight_r ? rom_q_s : spare_pixel_r;
          spare_first_r <= rd_first_r;
          spare_last_r  <= rd_last_r;
        end else begin
          out_valid_r   <= rd_inflight_r;
          out_pixel_r   <= rd_inflight_r ? rom_q_s : out_pixel_r;
          out_first_r   <= rd_first_r;
          out_last_r    <= rd_last_r;
        end
      end else if (rd_inflight_r) begin
        spare_valid_r <= 1'b1;
        spare_pixel_r <= rom_q_s;
        spare_first_r <= rd_first_r;
        spare_last_r  <= rd_last_r;
      end
    end
  end

  assign o_valid = out_valid_r;
  assign o_pixel = out_pixel_r;
  assign o_first = out_first_r;
  assign o_last  = out_last_r;
  assign o_busy  = busy_r;
  assign o_done  = done_r;

endmodule

// File: tb/tb_cnn_image_feeder.sv
// Directed bench for cnn_image_feeder using the built-in ROM pattern
// (word = image*1000 + index, mod 256).
module tb_cnn_image_feeder;

  localparam int NPIX = 784;
  localparam int MAXK = 3000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_start;
  logic [1:0] i_sel;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_pixel;
  logic       o_first;
  logic       o_last;
  logic       o_busy;
  logic       o_done;

  int total = 0;
  int bad   = 0;

  // captured frame
  logic [7:0] cap_pix [1024];
  logic       cap_fst [1024];
  logic       cap_lst [1024];
  int cap_n, cap_first_valid_k, cap_last_hs_k, cap_done_k, cap_done_cnt;
  int cap_busy_cnt, cap_gap_cnt, cap_unstable;
  bit cap_timeout;

  always #5 clk = ~clk;

  cnn_image_feeder #(.INIT_FILE("")) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (i_start),
    .i_sel   (i_sel),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_pixel (o_pixel),
    .o_first (o_first),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  function automatic logic [7:0] exp_pix(input int img, input int idx);
    int w;
    w = (img * 1000 + idx) % 256;
    return w[7:0];
  endfunction

  // pulse start for one edge; returns at the negedge after the accepting edge (k=0)
  task automatic start_frame(input logic [1:0] sel);
    i_start = 1'b1;
    i_sel   = sel;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // observe the stream each negedge; stop one cycle after o_done or after stop_at handshakes
  task automatic capture(input bit rand_ready, input int inj_at, input logic [1:0] inj_sel,
                         input int stop_at);
    int k;
    bit prev_stall, inj_done;
    logic [7:0] prev_pix;
    logic prev_f, prev_l;
    cap_n = 0; cap_first_valid_k = -1; cap_last_hs_k = -1; cap_done_k = -1;
    cap_done_cnt = 0; cap_busy_cnt = 0; cap_gap_cnt = 0; cap_unstable = 0;
    cap_timeout = 1'b0;
    prev_stall = 1'b0; inj_done = 1'b0;
    prev_pix = '0; prev_f = 1'b0; prev_l = 1'b0;
    k = 0;
    while (k < MAXK) begin
      if (prev_stall) begin
        if (!(o_valid === 1'b1 && o_pixel === prev_pix && o_first === prev_f && o_last === prev_l))
          cap_unstable++;
      end
      if (o_busy === 1'b1) cap_busy_cnt++;
      if (o_done === 1'b1) begin
        cap_done_cnt++;
        if (cap_done_k < 0) cap_done_k = k;
      end
      if (cap_done_k >= 0 && k == cap_done_k + 1) break;
      if (stop_at >= 0 && cap_n == stop_at) break;
      i_start = 1'b0;
      if (inj_at >= 0 && cap_n == inj_at && !inj_done) begin
        i_start  = 1'b1;
        i_sel    = inj_sel;
        inj_done = 1'b1;
      end
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid === 1'b1 && cap_first_valid_k < 0) cap_first_valid_k = k;
      if (o_valid !== 1'b1 && cap_first_valid_k >= 0 && cap_n < NPIX && cap_done_k < 0)
        cap_gap_cnt++;
      if (o_valid === 1'b1 && i_ready === 1'b1) begin
        if (cap_n < 1024) begin
          cap_pix[cap_n] = o_pixel;
          cap_fst[cap_n] = o_first;
          cap_lst[cap_n] = o_last;
        end
        cap_last_hs_k = k;
        cap_n++;
      end
      prev_stall = (o_valid === 1'b1) && (i_ready === 1'b0);
      prev_pix = o_pixel; prev_f = o_first; prev_l = o_last;
      @(negedge clk);
      k++;
    end
    if (k >= MAXK) cap_timeout = 1'b1;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    int activity;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_pixel !== 8'd0) begin bad++; $display("FAIL reset_pixel got=%0d exp=0", o_pixel); end
    total++; if ({o_first, o_last} !== 2'b00) begin bad++; $display("FAIL reset_marks got=%b exp=00", {o_first, o_last}); end
    total++; if ({o_busy, o_done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b exp=00", {o_busy, o_done}); end
    // mid-sim reset pulse, then idle with no start
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    total++; if ({o_valid, o_busy, o_done} !== 3'b000) begin bad++; $display("FAIL reset_async got=%b exp=000", {o_valid, o_busy, o_done}); end
    @(negedge clk);
    reset_n = 1'b1;
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1 || o_busy === 1'b1 || o_done === 1'b1) activity++;
    end
    total++; if (activity !== 0) begin bad++; $display("FAIL idle_no_stream got=%0d exp=0", activity); end
  endtask

  task automatic test_full_frame();
    start_frame(2'd1);
    capture(1'b0, -1, 2'd0, -1);
    total++; if (cap_timeout !== 1'b0) begin bad++; $display("FAIL t2_timeout got=%b exp=0", cap_timeout); end
    total++; if (cap_n !== NPIX) begin bad++; $display("FAIL t2_count got=%0d exp=%0d", cap_n, NPIX); end
    total++; if (cap_first_valid_k !== 2) begin bad++; $display("FAIL t2_latency got=%0d exp=2", cap_first_valid_k); end
    total++; if (cap_gap_cnt !== 0) begin bad++; $display("FAIL t2_gaps got=%0d exp=0", cap_gap_cnt); end
    total++; if (cap_busy_cnt !== 786) begin bad++; $display("FAIL t2_busy_cycles got=%0d exp=786", cap_busy_cnt); end
    total++; if (cap_done_k !== 786) begin bad++; $display("FAIL t2_done_cycle got=%0d exp=786", cap_done_k); end
    total++; if (cap_done_k !== cap_last_hs_k + 1) begin bad++; $display("FAIL t2_done_after_last got=%0d exp=%0d", cap_done_k, cap_last_hs_k + 1); end
    total++; if (cap_done_cnt !== 1) begin bad++; $display("FAIL t2_done_width got=%0d exp=1", cap_done_cnt); end
    for (int i = 0; i < NPIX && i < cap_n; i++) begin
      total++;
      if ({cap_pix[i], cap_fst[i], cap_lst[i]} !== {exp_pix(1, i), i == 0, i == NPIX - 1}) begin
        bad++;
        $display("FAIL t2_pixel idx=%0d got=%0d/%b/%b exp=%0d/%b/%b", i, cap_pix[i], cap_fst[i],
                 cap_lst[i], exp_pix(1, i), i == 0, i == NPIX - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    start_frame(2'd1);
    capture(1'b1, -1, 2'd0, -1);
    total++; if (cap_timeout !== 1'b0) begin bad++; $display("FAIL t3_timeout got=%b exp=0", cap_timeout); end
    total++; if (cap_n !== NPIX) begin bad++; $display("FAIL t3_count got=%0d exp=%0d", cap_n, NPIX); end
    total++; if (cap_unstable !== 0) begin bad++; $display("FAIL t3_stall_stable got=%0d exp=0", cap_unstable); end
    total++; if (cap_done_cnt !== 1) begin bad++; $display("FAIL t3_done_width got=%0d exp=1", cap_done_cnt); end
    total++; if (cap_done_k !== cap_last_hs_k + 1) begin bad++; $display("FAIL t3_done_after_last got=%0d exp=%0d", cap_done_k, cap_last_hs_k + 1); end
    for (int i = 0; i < NPIX && i < cap_n; i++) begin
      total++;
      if ({cap_pix[i], cap_fst[i], cap_lst[i]} !== {exp_pix(1, i), i == 0, i == NPIX - 1}) begin
        bad++;
        $display("FAIL t3_pixel idx=%0d got=%0d/%b/%b exp=%0d/%b/%b", i, cap_pix[i], cap_fst[i],
                 cap_lst[i], exp_pix(1, i), i == 0, i == NPIX - 1);
      end
    end
  endtask

  task automatic test_restart_ignored();
    start_frame(2'd1);
    capture(1'b0, 100, 2'd3, -1);
    total++; if (cap_n !== NPIX) begin bad++; $display("FAIL t4_count got=%0d exp=%0d", cap_n, NPIX); end
    total++; if (cap_done_k !== 786) begin bad++; $display("FAIL t4_done_cycle got=%0d exp=786", cap_done_k); end
    for (int i = 0; i < NPIX && i < cap_n; i++) begin
      total++;
      if (cap_pix[i] !== exp_pix(1, i)) begin
        bad++;
        $display("FAIL t4_pixel_img1 idx=%0d got=%0d exp=%0d", i, cap_pix[i], exp_pix(1, i));
      end
    end
    // capture returned in the IDLE cycle right after DONE
    start_frame(2'd3);
    capture(1'b0, -1, 2'd0, -1);
    total++; if (cap_n !== NPIX) begin bad++; $display("FAIL t4_next_count got=%0d exp=%0d", cap_n, NPIX); end
    total++; if (cap_first_valid_k !== 2) begin bad++; $display("FAIL t4_next_latency got=%0d exp=2", cap_first_valid_k); end
    for (int i = 0; i < NPIX && i < cap_n; i++) begin
      total++;
      if (cap_pix[i] !== exp_pix(3, i)) begin
        bad++;
        $display("FAIL t4_pixel_img3 idx=%0d got=%0d exp=%0d", i, cap_pix[i], exp_pix(3, i));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int late_done;
    start_frame(2'd1);
    capture(1'b0, -1, 2'd0, 400);
    total++; if (cap_n !== 400) begin bad++; $display("FAIL t5_abort_point got=%0d exp=400", cap_n); end
    reset_n = 1'b0;
    #2;
    total++; if ({o_valid, o_busy, o_done} !== 3'b000) begin bad++; $display("FAIL t5_reset_outputs got=%b exp=000", {o_valid, o_busy, o_done}); end
    @(negedge clk);
    reset_n = 1'b1;
    late_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_valid === 1'b1) late_done++;
    end
    total++; if (late_done !== 0) begin bad++; $display("FAIL t5_no_done got=%0d exp=0", late_done); end
    start_frame(2'd2);
    capture(1'b0, -1, 2'd0, -1);
    total++; if (cap_n !== NPIX) begin bad++; $display("FAIL t5_count got=%0d exp=%0d", cap_n, NPIX); end
    total++; if ({cap_pix[0], cap_fst[0]} !== {exp_pix(2, 0), 1'b1}) begin bad++; $display("FAIL t5_first got=%0d/%b exp=%0d/1", cap_pix[0], cap_fst[0], exp_pix(2, 0)); end
    total++; if (cap_done_cnt !== 1) begin bad++; $display("FAIL t5_done_width got=%0d exp=1", cap_done_cnt); end
    for (int i = 0; i < NPIX && i < cap_n; i++) begin
      total++;
      if (cap_pix[i] !== exp_pix(2, i)) begin
        bad++;
        $display("FAIL t5_pixel idx=%0d got=%0d exp=%0d", i, cap_pix[i], exp_pix(2, i));
      end
    end
  endtask

  task automatic test_sel_bounds();
    // image 0: ROM words 0 and 783
    start_frame(2'd0);
    capture(1'b0, -1, 2'd0, -1);
    total++; if (cap_n !== NPIX) begin bad++; $display("FAIL t6_img0_count got=%0d exp=%0d", cap_n, NPIX); end
    total++; if ({cap_pix[0], cap_fst[0]} !== {8'd0, 1'b1}) begin bad++; $display("FAIL t6_word0 got=%0d/%b exp=0/1", cap_pix[0], cap_fst[0]); end
    total++; if ({cap_pix[NPIX-1], cap_lst[NPIX-1]} !== {8'd15, 1'b1}) begin bad++; $display("FAIL t6_word783 got=%0d/%b exp=15/1", cap_pix[NPIX-1], cap_lst[NPIX-1]); end
    // image 3: ROM words 2352 and 3135
    start_frame(2'd3);
    capture(1'b0, -1, 2'd0, -1);
    total++; if (cap_n !== NPIX) begin bad++; $display("FAIL t6_img3_count got=%0d exp=%0d", cap_n, NPIX); end
    total++; if ({cap_pix[0], cap_fst[0]} !== {8'd184, 1'b1}) begin bad++; $display("FAIL t6_word2352 got=%0d/%b exp=184/1", cap_pix[0], cap_fst[0]); end
    total++; if ({cap_pix[NPIX-1], cap_lst[NPIX-1]} !== {8'd199, 1'b1}) begin bad++; $display("FAIL t6_word3135 got=%0d/%b exp=199/1", cap_pix[NPIX-1], cap_lst[NPIX-1]); end
  endtask

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0;
    i_sel   = 2'd0;
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_frame();
    test_sel_bounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
